// File: rtl/bcd_pkg.sv
// Shared types for the BCD step counter:
// debounce states, digit type and digit limit.
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_REL} db_state_t;
   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   function automatic logic is_bcd(input bcd_t v);
      return v <= BCD_MAX;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debounce FSM.
// Emits the debounced level and one step request per accepted press.
module btn_debounce
   import bcd_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000,
   parameter int CNT_W     = $clog2(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step_btn,
   output logic btn_state,
   output logic step_req
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   db_state_t        state;
   db_state_t        state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             cnt_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= step_btn;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   assign cnt_done = (cnt == CNT_LAST);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (sync_q2) begin
               state_nx = ARM_PRESS;
               cnt_nx   = '0;
            end
         end
         ARM_PRESS: begin
            if (!sync_q2)
               state_nx = IDLE;
            else if (cnt_done)
               state_nx = HELD;
            else
               cnt_nx = cnt + CNT_W'(1);
         end
         HELD: begin
            if (!sync_q2) begin
               state_nx = ARM_REL;
               cnt_nx   = '0;
            end
         end
         ARM_REL: begin
            if (sync_q2)
               state_nx = HELD;
            else if (cnt_done)
               state_nx = IDLE;
            else
               cnt_nx = cnt + CNT_W'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request fires only on the press-acceptance transition, so holds never repeat
   always_comb begin
      btn_state = (state == HELD) || (state == ARM_REL);
      step_req  = (state == ARM_PRESS) && sync_q2 && cnt_done;
   end
endmodule

// File: rtl/bcd_step_counter.sv
// Mod-10 BCD up/down counter stepped by a debounced button or a prescaler tick,
// with parallel load and one-cycle carry/borrow/load-error pulses.
module bcd_step_counter
   import bcd_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up_dn,
   input  logic       auto_mode,
   input  logic       step_btn,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] bcd_code,
   output logic       carry,
   output logic       borrow,
   output logic       load_err,
   output logic       btn_state
);
   localparam int CNT_W =
      $clog2((TICK_DIV > DB_CYCLES) ? TICK_DIV : DB_CYCLES);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] pre_cnt;
   logic             pre_run;
   logic             tick;
   logic             step_req;
   logic             step;
   logic             load_ok;
   bcd_t             bcd_nx;
   logic             carry_nx;
   logic             borrow_nx;
   logic             load_err_nx;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .step_btn  (step_btn),
      .btn_state (btn_state),
      .step_req  (step_req)
   );

   assign pre_run = auto_mode & en;
   assign tick    = pre_run & (pre_cnt == TICK_LAST);
   assign step    = en & (auto_mode ? tick : step_req);
   assign load_ok = is_bcd(load_val);

   // Prescaler parks at zero whenever it is not running
   always_ff @(posedge clk) begin
      if (!rst_n)
         pre_cnt <= '0;
      else if (!pre_run || tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + CNT_W'(1);
   end

   always_comb begin
      bcd_nx      = bcd_code;
      carry_nx    = 1'b0;
      borrow_nx   = 1'b0;
      load_err_nx = 1'b0;
      unique case (1'b1)
         load & load_ok:
            bcd_nx = load_val;
         load & ~load_ok:
            load_err_nx = 1'b1;
         ~load & step & up_dn: begin
            carry_nx = (bcd_code == BCD_MAX);
            bcd_nx   = carry_nx ? 4'd0 : bcd_code + 4'd1;
         end
         ~load & step & ~up_dn: begin
            borrow_nx = (bcd_code == 4'd0);
            bcd_nx    = borrow_nx ? BCD_MAX : bcd_code - 4'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcd_code <= '0;
         carry    <= 1'b0;
         borrow   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         bcd_code <= bcd_nx;
         carry    <= carry_nx;
         borrow   <= borrow_nx;
         load_err <= load_err_nx;
      end
   end
endmodule

// File: tb/tb_bcd_step_counter.sv
// Bench for bcd_step_counter: vector table, directed corner sequences
// and randomized traffic against a behavioural digit/button model.
module tb_bcd_step_counter;
   localparam int TD = 4;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       auto_mode = 1'b0;
   logic       step_btn = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] bcd_code;
   logic       carry;
   logic       borrow;
   logic       load_err;
   logic       btn_state;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit hist[$] = {1'b0, 1'b0};
   bit m_level = 1'b0;
   int m_run = 0;
   int m_phase = 0;
   int m_digit = 0;
   bit m_carry = 1'b0;
   bit m_borrow = 1'b0;
   bit m_err = 1'b0;

   typedef struct {
      bit       r;
      bit       e;
      bit       u;
      bit       a;
      bit       l;
      bit [3:0] lv;
      int       rpt;
      int       bcd;
      bit       c;
      bit       b;
      bit       er;
   } vec_t;

   bcd_step_counter #(
      .TICK_DIV  (TD),
      .DB_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .up_dn     (up_dn),
      .auto_mode (auto_mode),
      .step_btn  (step_btn),
      .load      (load),
      .load_val  (load_val),
      .bcd_code  (bcd_code),
      .carry     (carry),
      .borrow    (borrow),
      .load_err  (load_err),
      .btn_state (btn_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // The button is accepted once its synced level has differed from the
   // debounced level for DB+1 consecutive samples.
   task automatic model_edge();
      bit sync;
      bit press;
      bit tk;
      bit stp;
      if (!rst_n) begin
         hist = {1'b0, 1'b0};
         m_level = 1'b0;
         m_run = 0;
         m_phase = 0;
         m_digit = 0;
         m_carry = 1'b0;
         m_borrow = 1'b0;
         m_err = 1'b0;
         return;
      end
      sync = hist[0];
      press = 1'b0;
      if (sync != m_level) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_level = sync;
            m_run = 0;
            press = sync;
         end
      end else begin
         m_run = 0;
      end
      tk = 1'b0;
      if (auto_mode && en) begin
         tk = ((m_phase % TD) == TD - 1);
         m_phase++;
      end else begin
         m_phase = 0;
      end
      stp = en && (auto_mode ? tk : press);
      m_carry = 1'b0;
      m_borrow = 1'b0;
      m_err = 1'b0;
      if (load) begin
         if (int'(load_val) <= 9) m_digit = int'(load_val);
         else m_err = 1'b1;
      end else if (stp) begin
         if (up_dn) begin
            m_carry = (m_digit == 9);
            m_digit = (m_digit + 1) % 10;
         end else begin
            m_borrow = (m_digit == 0);
            m_digit = (m_digit + 9) % 10;
         end
      end
      void'(hist.pop_front());
      hist.push_back(step_btn);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_bcd", int'(bcd_code), m_digit);
      chk("model_carry", int'(carry), int'(m_carry));
      chk("model_borrow", int'(borrow), int'(m_borrow));
      chk("model_load_err", int'(load_err), int'(m_err));
      chk("model_btn_state", int'(btn_state), int'(m_level));
   endtask

   function automatic vec_t v(bit r, bit e, bit u, bit a, bit l, int lv,
                              int n, int b, bit c, bit bo, bit er);
      vec_t x;
      x.r = r; x.e = e; x.u = u; x.a = a; x.l = l;
      x.lv = 4'(lv); x.rpt = n; x.bcd = b; x.c = c; x.b = bo; x.er = er;
      return x;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      load = 1'b0;
      step_btn = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[$];
      int ncar;
      int nchg;
      int rise;
      logic [3:0] prev;

      //          r e u a l lv  n  bcd c b er
      tbl.push_back(v(0,1,1,0,0, 0, 2, 0,0,0,0));
      tbl.push_back(v(1,1,0,0,1, 1, 1, 1,0,0,0));
      tbl.push_back(v(1,1,0,1,0, 0, 3, 1,0,0,0));
      tbl.push_back(v(1,1,0,1,0, 0, 1, 0,0,0,0));
      tbl.push_back(v(1,1,0,1,0, 0, 3, 0,0,0,0));
      tbl.push_back(v(1,1,0,1,0, 0, 1, 9,0,1,0));
      tbl.push_back(v(1,1,0,1,0, 0, 1, 9,0,0,0));
      tbl.push_back(v(1,1,1,1,1,12, 1, 9,0,0,1));
      tbl.push_back(v(1,1,1,1,0, 0, 1, 9,0,0,0));
      tbl.push_back(v(1,1,1,1,1, 7, 1, 7,0,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 4, 8,0,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 4, 9,0,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 4, 0,1,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 1, 0,0,0,0));
      tbl.push_back(v(1,0,1,1,0, 0,20, 0,0,0,0));
      tbl.push_back(v(1,0,1,1,1, 3, 1, 3,0,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 3, 3,0,0,0));
      tbl.push_back(v(1,1,1,1,0, 0, 1, 4,0,0,0));

      step_btn = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].r;
         en = tbl[i].e;
         up_dn = tbl[i].u;
         auto_mode = tbl[i].a;
         load = tbl[i].l;
         load_val = tbl[i].lv;
         repeat (tbl[i].rpt) cycle();
         chk($sformatf("tbl%0d_bcd", i), int'(bcd_code), tbl[i].bcd);
         chk($sformatf("tbl%0d_carry", i), int'(carry), int'(tbl[i].c));
         chk($sformatf("tbl%0d_borrow", i), int'(borrow), int'(tbl[i].b));
         chk($sformatf("tbl%0d_err", i), int'(load_err), int'(tbl[i].er));
      end

      // Full up-count wrap: ten ticks, one carry
      do_reset();
      auto_mode = 1'b1;
      en = 1'b1;
      up_dn = 1'b1;
      ncar = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (carry) ncar++;
         if (i == 39) chk("wrap_last_carry", int'(carry), 1);
      end
      chk("wrap_carry_count", ncar, 1);
      chk("wrap_final_bcd", int'(bcd_code), 0);

      // Bouncy press then long hold and release
      do_reset();
      auto_mode = 1'b0;
      en = 1'b1;
      up_dn = 1'b1;
      nchg = 0;
      rise = -1;
      prev = bcd_code;
      for (int k = 0; k < 32; k++) begin
         step_btn = (k == 0) || (k >= 2 && k <= 21);
         cycle();
         if (bcd_code != prev) nchg++;
         prev = bcd_code;
         if (btn_state && rise < 0) rise = k;
      end
      chk("db_step_count", nchg, 1);
      chk("db_final_bcd", int'(bcd_code), 1);
      chk("db_rise_cycle", rise, 7);
      chk("db_released", int'(btn_state), 0);

      // Reset while the press is still being qualified
      load = 1'b1;
      load_val = 4'd5;
      cycle();
      load = 1'b0;
      step_btn = 1'b1;
      repeat (3) cycle();
      chk("mid_pre_bcd", int'(bcd_code), 5);
      chk("mid_pre_btn", int'(btn_state), 0);
      rst_n = 1'b0;
      step_btn = 1'b0;
      cycle();
      chk("mid_rst_bcd", int'(bcd_code), 0);
      chk("mid_rst_btn", int'(btn_state), 0);
      rst_n = 1'b1;
      repeat (10) cycle();
      chk("mid_after_bcd", int'(bcd_code), 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(199) != 0);
         en = ($urandom_range(9) != 0);
         up_dn = 1'($urandom_range(1));
         if ($urandom_range(49) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(5) == 0) step_btn = ~step_btn;
         load = ($urandom_range(19) == 0);
         load_val = 4'($urandom_range(15));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
